// File: rtl/apb_timer_mch.sv
// Multi-channel APB timer: NCH independent prescaled up-counters with compare match,
// periodic/one-shot mode, sticky W1C match flags and one maskable interrupt line.
module apb_timer_mch #(
    parameter int NCH = 4,
    parameter int CW  = 32
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        PSEL,
    input  logic [5:0]  PADDR,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        IRQ
);

    localparam logic [31:0]   UNMAPPED = 32'hDEADBEEF;
    localparam logic [CW-1:0] ONE      = {{(CW-1){1'b0}}, 1'b1};

    localparam logic [5:0] ADDR_IRQEN = 6'h20;
    localparam logic [5:0] ADDR_STAT  = 6'h21;
    localparam logic [5:0] ADDR_RIS   = 6'h22;

    localparam logic [1:0] REG_CTRL = 2'd0;
    localparam logic [1:0] REG_PRE  = 2'd1;
    localparam logic [1:0] REG_CMP  = 2'd2;
    localparam logic [1:0] REG_CNT  = 2'd3;

    logic [NCH-1:0] en;
    logic [NCH-1:0] oneshot;
    logic [NCH-1:0] stat;
    logic [NCH-1:0] irqen;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] hit;
    logic [NCH-1:0] stat_clr;

    logic [CW-1:0] pre  [NCH];
    logic [CW-1:0] cmp  [NCH];
    logic [CW-1:0] cnt  [NCH];
    logic [CW-1:0] pcnt [NCH];

    logic       wr;
    logic       chan_space;
    logic [2:0] ch_idx;
    logic [1:0] reg_idx;

    assign wr         = PSEL & PWRITE & PENABLE;
    assign chan_space = ~PADDR[5];
    assign ch_idx     = PADDR[4:2];
    assign reg_idx    = PADDR[1:0];

    assign PREADY = 1'b1;
    assign IRQ    = |(stat & irqen);

    // A tick is the prescaler wrapping; a hit is a tick while the count equals compare.
    always_comb begin
        tick = '0;
        hit  = '0;
        for (int c = 0; c < NCH; c++) begin
            tick[c] = en[c] && (pcnt[c] == pre[c]);
            hit[c]  = tick[c] && (cnt[c] == cmp[c]);
        end
    end

    always_comb begin
        stat_clr = '0;
        if (wr && PADDR == ADDR_STAT) begin
            stat_clr = PWDATA[NCH-1:0];
        end
    end

    // Channel datapath first, then register writes, so a CTRL write overrides one-shot auto-clear.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            en      <= '0;
            oneshot <= '0;
            for (int c = 0; c < NCH; c++) begin
                pre[c]  <= '0;
                cmp[c]  <= '0;
                cnt[c]  <= '0;
                pcnt[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (en[c]) begin
                    if (tick[c]) begin
                        pcnt[c] <= '0;
                        if (hit[c]) begin
                            cnt[c] <= '0;
                            if (oneshot[c]) begin
                                en[c] <= 1'b0;
                            end
                        end else begin
                            cnt[c] <= cnt[c] + ONE;
                        end
                    end else begin
                        pcnt[c] <= pcnt[c] + ONE;
                    end
                end

                if (wr && chan_space && ch_idx == 3'(c)) begin
                    case (reg_idx)
                        REG_CTRL: begin
                            en[c]      <= PWDATA[0];
                            oneshot[c] <= PWDATA[1];
                            if (PWDATA[2]) begin
                                pcnt[c] <= '0;
                                cnt[c]  <= '0;
                            end
                        end
                        REG_PRE: pre[c] <= PWDATA[CW-1:0];
                        REG_CMP: cmp[c] <= PWDATA[CW-1:0];
                        default: ;
                    endcase
                end
            end
        end
    end

    // A hardware match in the same cycle as a W1C keeps the flag set.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            stat  <= '0;
            irqen <= '0;
        end else begin
            stat <= (stat & ~stat_clr) | hit;
            if (wr && PADDR == ADDR_IRQEN) begin
                irqen <= PWDATA[NCH-1:0];
            end
        end
    end

    always_comb begin
        PRDATA = UNMAPPED;
        if (chan_space) begin
            for (int c = 0; c < NCH; c++) begin
                if (ch_idx == 3'(c)) begin
                    case (reg_idx)
                        REG_CTRL: PRDATA = {30'b0, oneshot[c], en[c]};
                        REG_PRE:  PRDATA = 32'(pre[c]);
                        REG_CMP:  PRDATA = 32'(cmp[c]);
                        REG_CNT:  PRDATA = 32'(cnt[c]);
                        default:  PRDATA = UNMAPPED;
                    endcase
                end
            end
        end else begin
            case (PADDR)
                ADDR_IRQEN: PRDATA = 32'(irqen);
                ADDR_STAT:  PRDATA = 32'(stat);
                ADDR_RIS:   PRDATA = 32'(stat & irqen);
                default:    PRDATA = UNMAPPED;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_timer_mch.sv
// Self-checking bench for apb_timer_mch (NCH=4, CW=8): reset, periodic, prescale/one-shot,
// IRQ and W1C races, compare-below-count wrap, width truncation, multi-channel and reset priority.
`timescale 1ns/1ps
module tb_apb_timer_mch;
    localparam int NCH = 4;
    localparam int CW  = 8;

    localparam logic [5:0] IRQEN = 6'h20;
    localparam logic [5:0] STAT  = 6'h21;
    localparam logic [5:0] RIS   = 6'h22;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        PSEL;
    logic [5:0]  PADDR;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        IRQ;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    apb_timer_mch #(.NCH(NCH), .CW(CW)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PADDR(PADDR), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .IRQ(IRQ)
    );

    // clock / reset
    always #5 PCLK = ~PCLK;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [5:0] ra(input int c, input int r);
        return 6'(c * 4 + r);
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic step(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    // Returns 1ns after the edge that commits the write (setup edge, then access edge).
    task automatic apb_write(input logic [5:0] addr, input logic [31:0] data);
        PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = addr; PWDATA = data;
        @(posedge PCLK);
        #1 PENABLE = 1'b1;
        @(posedge PCLK);
        #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    // Zero-wait read sampled between edges; PRDATA is combinational from PADDR.
    task automatic read_check(input string tag, input logic [5:0] addr, input logic [31:0] exp);
        logic [31:0] got;
        exp_q.push_back(exp);
        PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b1; PADDR = addr;
        #0.2;
        got = PRDATA;
        PSEL = 1'b0; PENABLE = 1'b0;
        check_val(tag, got, exp_q.pop_front());
    endtask

    task automatic irq_check(input string tag, input logic exp);
        exp_q.push_back({31'b0, exp});
        check_val(tag, {31'b0, IRQ}, exp_q.pop_front());
    endtask

    initial begin
        int exp_cnt [5];
        exp_cnt = '{0, 1, 2, 3, 0};
        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;

        // reset
        repeat (2) @(posedge PCLK);
        #1 PRESET = 1'b0;
        for (int c = 0; c < NCH; c++)
            for (int r = 0; r < 4; r++)
                read_check($sformatf("rst_ch%0d_r%0d", c, r), ra(c, r), 32'h0);
        read_check("rst_irqen", IRQEN, 32'h0);
        read_check("rst_stat", STAT, 32'h0);
        read_check("rst_ris", RIS, 32'h0);
        read_check("rst_unmapped_8c", 6'h23, 32'hDEADBEEF);
        read_check("rst_ch4_ctrl", ra(4, 0), 32'hDEADBEEF);
        read_check("rst_ch7_cnt", ra(7, 3), 32'hDEADBEEF);
        irq_check("rst_irq", 1'b0);

        // periodic ch0: PRE=0 CMP=3 -> period 4
        apb_write(ra(0, 1), 0);
        apb_write(ra(0, 2), 3);
        apb_write(ra(0, 0), 1);
        for (int i = 0; i < 5; i++) begin
            read_check($sformatf("per_cnt%0d", i), ra(0, 3), 32'(exp_cnt[i]));
            read_check($sformatf("per_stat%0d", i), STAT, (i == 4) ? 32'h1 : 32'h0);
            if (i < 4) step(1);
        end
        apb_write(STAT, 1);
        read_check("per_w1c_stat", STAT, 32'h0);
        read_check("per_w1c_cnt", ra(0, 3), 32'd2);
        step(2);
        read_check("per_rematch_stat", STAT, 32'h1);
        read_check("per_rematch_cnt", ra(0, 3), 32'd0);
        irq_check("per_masked_irq", 1'b0);
        apb_write(ra(0, 0), 0);
        read_check("per_stop_cnt", ra(0, 3), 32'd2);
        read_check("per_stop_ctrl", ra(0, 0), 32'd0);
        step(3);
        read_check("per_hold_cnt", ra(0, 3), 32'd2);
        apb_write(ra(0, 0), 4);
        read_check("per_restart_cnt", ra(0, 3), 32'd0);
        read_check("per_restart_ctrl", ra(0, 0), 32'd0);
        apb_write(STAT, 1);
        read_check("per_clear_stat", STAT, 32'h0);

        // prescale + one-shot ch1: PRE=2 CMP=1 -> flag 6 cycles after enable
        apb_write(IRQEN, 2);
        apb_write(ra(1, 1), 2);
        apb_write(ra(1, 2), 1);
        apb_write(ra(1, 0), 3);
        read_check("os_stat_e0", STAT, 32'h0);
        irq_check("os_irq_e0", 1'b0);
        step(5);
        read_check("os_stat_e5", STAT, 32'h0);
        read_check("os_cnt_e5", ra(1, 3), 32'd1);
        irq_check("os_irq_e5", 1'b0);
        step(1);
        read_check("os_stat_e6", STAT, 32'h2);
        read_check("os_ris_e6", RIS, 32'h2);
        read_check("os_ctrl_e6", ra(1, 0), 32'h2);
        read_check("os_cnt_e6", ra(1, 3), 32'd0);
        irq_check("os_irq_e6", 1'b1);
        step(3);
        read_check("os_cnt_held", ra(1, 3), 32'd0);
        read_check("os_stat_sticky", STAT, 32'h2);
        apb_write(STAT, 2);
        read_check("os_w1c_stat", STAT, 32'h0);
        irq_check("os_w1c_irq", 1'b0);

        // match in the W1C cycle: set wins
        apb_write(ra(1, 0), 7);
        step(4);
        apb_write(STAT, 2);
        read_check("race_w1c_stat", STAT, 32'h2);
        irq_check("race_w1c_irq", 1'b1);
        apb_write(STAT, 2);
        read_check("race_clear_stat", STAT, 32'h0);

        // CTRL write in the one-shot auto-clear cycle: write wins
        apb_write(ra(1, 0), 7);
        step(4);
        apb_write(ra(1, 0), 1);
        read_check("race_ctrl_ctrl", ra(1, 0), 32'h1);
        read_check("race_ctrl_stat", STAT, 32'h2);
        apb_write(ra(1, 0), 0);
        apb_write(STAT, 32'hF);
        read_check("race_ctrl_clear", STAT, 32'h0);

        // wrap: CNT=10 when CMP drops to 5 -> through 255, 0, match at 5
        apb_write(ra(2, 1), 0);
        apb_write(ra(2, 2), 200);
        apb_write(ra(2, 0), 5);
        step(8);
        apb_write(ra(2, 2), 5);
        read_check("wrap_cnt10", ra(2, 3), 32'd10);
        read_check("wrap_cmp", ra(2, 2), 32'd5);
        step(245);
        read_check("wrap_cnt255", ra(2, 3), 32'd255);
        read_check("wrap_stat255", STAT, 32'h0);
        step(1);
        read_check("wrap_cnt0", ra(2, 3), 32'd0);
        read_check("wrap_stat0", STAT, 32'h0);
        step(5);
        read_check("wrap_cnt5", ra(2, 3), 32'd5);
        read_check("wrap_stat5", STAT, 32'h0);
        step(1);
        read_check("wrap_match_stat", STAT, 32'h4);
        read_check("wrap_match_cnt", ra(2, 3), 32'd0);
        apb_write(ra(2, 0), 0);
        apb_write(STAT, 32'hF);

        // values truncated to CW bits
        apb_write(ra(3, 1), 32'h1234_5678);
        read_check("width_pre", ra(3, 1), 32'h78);
        apb_write(ra(3, 2), 32'hFFFF_FF00);
        read_check("width_cmp", ra(3, 2), 32'h0);
        apb_write(IRQEN, 32'hFFFF_FFF5);
        read_check("width_irqen", IRQEN, 32'h5);

        // multi-channel: CMP=0 PRE=0 on all -> every channel matches every cycle
        for (int c = 0; c < NCH; c++) begin
            apb_write(ra(c, 1), 0);
            apb_write(ra(c, 2), 0);
        end
        apb_write(IRQEN, 32'hF);
        for (int c = 0; c < NCH; c++) apb_write(ra(c, 0), 5);
        step(1);
        read_check("multi_stat", STAT, 32'hF);
        read_check("multi_ris", RIS, 32'hF);
        irq_check("multi_irq", 1'b1);
        apb_write(ra(5, 1), 123);
        for (int r = 0; r < 4; r++)
            read_check($sformatf("multi_ch5_r%0d", r), ra(5, r), 32'hDEADBEEF);
        apb_write(STAT, 32'hF);
        read_check("multi_w1c_stat", STAT, 32'hF);

        // reset wins over a same-cycle write
        PRESET = 1'b1;
        PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b1; PADDR = ra(0, 2); PWDATA = 32'h55;
        @(posedge PCLK);
        #1;
        PRESET = 1'b0; PSEL = 1'b0; PWRITE = 1'b0; PENABLE = 1'b0;
        irq_check("rst2_irq", 1'b0);
        read_check("rst2_cmp0", ra(0, 2), 32'h0);
        read_check("rst2_ctrl0", ra(0, 0), 32'h0);
        read_check("rst2_irqen", IRQEN, 32'h0);
        read_check("rst2_stat", STAT, 32'h0);
        step(3);
        read_check("rst2_stat_idle", STAT, 32'h0);
        read_check("rst2_cnt3", ra(3, 3), 32'h0);

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
